// File: rtl/rx_fb_pkg.sv
// Shared types and widths for the receive frame buffer.
package rx_fb_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned WORD_W     = 17;
    localparam int unsigned LAST_BIT   = 16;
    localparam int unsigned FRM_CNT_W  = 8;
    localparam int unsigned STAT_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } fb_state_e;

    // Stored buffer word: bit LAST_BIT flags the final word of a frame.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fb_word_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
        return (&v) ? v : v + STAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rx_frame_buffer_if.sv
// Frame input, readout port and status bundle of the receive frame buffer.
interface rx_frame_buffer_if;
    import rx_fb_pkg::*;

    logic [DATA_W-1:0]     FRM_DATA;
    logic                  FRM_DATA_VALID;
    logic                  GOOD_CRC;
    logic                  CRC_CHK_VLD;
    logic                  RD_EN;
    logic [DATA_W-1:0]     DOUT;
    logic                  DOUT_LAST;
    logic                  DOUT_VALID;
    logic                  EMPTY;
    logic                  FF_FULL;
    logic                  FF_AF;
    logic [FRM_CNT_W-1:0]  FRM_CNT;
    logic [STAT_CNT_W-1:0] GOOD_FRM_CNT;
    logic [STAT_CNT_W-1:0] BAD_FRM_CNT;

    modport master (
        output FRM_DATA, FRM_DATA_VALID, GOOD_CRC, CRC_CHK_VLD, RD_EN,
        input  DOUT, DOUT_LAST, DOUT_VALID, EMPTY, FF_FULL, FF_AF,
               FRM_CNT, GOOD_FRM_CNT, BAD_FRM_CNT
    );

    modport slave (
        input  FRM_DATA, FRM_DATA_VALID, GOOD_CRC, CRC_CHK_VLD, RD_EN,
        output DOUT, DOUT_LAST, DOUT_VALID, EMPTY, FF_FULL, FF_AF,
               FRM_CNT, GOOD_FRM_CNT, BAD_FRM_CNT
    );

endinterface

// File: rtl/rx_fb_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module rx_fb_dpram
    import rx_fb_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  fb_word_t          wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output fb_word_t          rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    fb_word_t mem_q [DEPTH];
    fb_word_t rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; cleared so DOUT reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_frame_buffer.sv
// Captures received frames, commits on good CRC or rolls back, and serves committed words.
module rx_frame_buffer
    import rx_fb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned MAX_WORDS = 812,
    parameter int unsigned AF_MARGIN = 816,
    parameter int unsigned CRC_TMO   = 64
) (
    input  logic         CLK,
    input  logic         RST,
    rx_frame_buffer_if.slave bus
);

    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 2);
    localparam int unsigned TMR_W  = $clog2(CRC_TMO + 1);

    fb_state_e             state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      cmt_ptr_q, cmt_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic                  ovf_q, ovf_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  pend_q, pend_d;
    logic                  pend_good_q, pend_good_d;
    logic [FRM_CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
    logic [STAT_CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [STAT_CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic                  dvalid_q, dvalid_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  af_q, af_d;

    logic [PTR_W-1:0]      occ;
    logic                  space;
    logic                  rd_acc;
    logic                  commit, rollback, start;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    fb_word_t              ram_wdata;
    fb_word_t              ram_rdata;

    rx_fb_dpram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (CLK),
        .rst_n_i (RST),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next-state logic: frame capture FSM, pointers, counters and flags.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        hold_d      = hold_q;
        wcnt_d      = wcnt_q;
        ovf_d       = ovf_q;
        tmr_d       = tmr_q;
        pend_d      = 1'b0;
        pend_good_d = 1'b0;
        frm_cnt_d   = frm_cnt_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        commit      = 1'b0;
        rollback    = 1'b0;
        start       = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_ptr_q[ADDR_W-1:0];
        ram_wdata   = '{last: 1'b0, data: hold_q};

        occ    = wr_ptr_q - rd_ptr_q;
        space  = (occ != PTR_W'(DEPTH));
        rd_acc = bus.RD_EN && !empty_q;

        unique case (state_q)
            IDLE: begin
                if (bus.FRM_DATA_VALID) begin
                    start = 1'b1;
                end
            end
            RECV: begin
                if (pend_q) begin
                    // Last word arrived with the check pulse; decide now.
                    if (pend_good_q && !ovf_q && space) begin
                        commit = 1'b1;
                    end else begin
                        rollback = 1'b1;
                    end
                    if (bus.FRM_DATA_VALID) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.FRM_DATA_VALID) begin
                    tmr_d = '0;
                    if (!ovf_q && space && (wcnt_q < WCNT_W'(MAX_WORDS))) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        hold_d   = bus.FRM_DATA;
                        wcnt_d   = wcnt_q + WCNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (bus.CRC_CHK_VLD) begin
                        pend_d      = 1'b1;
                        pend_good_d = bus.GOOD_CRC;
                    end
                end else if (bus.CRC_CHK_VLD) begin
                    if (bus.GOOD_CRC && !ovf_q && space) begin
                        commit = 1'b1;
                    end else begin
                        rollback = 1'b1;
                    end
                    state_d = IDLE;
                end else if (tmr_q == TMR_W'(CRC_TMO - 1)) begin
                    rollback = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            ram_we     = 1'b1;
            ram_wdata  = '{last: 1'b1, data: hold_q};
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            cmt_ptr_d  = wr_ptr_q + PTR_W'(1);
            good_cnt_d = sat_inc(good_cnt_q);
        end

        if (rollback) begin
            wr_ptr_d  = cmt_ptr_q;
            bad_cnt_d = sat_inc(bad_cnt_q);
        end

        if (start) begin
            state_d     = RECV;
            hold_d      = bus.FRM_DATA;
            wcnt_d      = WCNT_W'(1);
            ovf_d       = 1'b0;
            tmr_d       = '0;
            pend_d      = bus.CRC_CHK_VLD;
            pend_good_d = bus.GOOD_CRC;
        end

        // Frame count: commit and last-word readout cancel each other.
        unique case ({commit, dvalid_q && ram_rdata.last})
            2'b10:   if (frm_cnt_q != '1) frm_cnt_d = frm_cnt_q + FRM_CNT_W'(1);
            2'b01:   if (frm_cnt_q != '0) frm_cnt_d = frm_cnt_q - FRM_CNT_W'(1);
            default: frm_cnt_d = frm_cnt_q;
        endcase

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        dvalid_d = rd_acc;
        empty_d  = (rd_ptr_d == cmt_ptr_d);
        full_d   = (occ == PTR_W'(DEPTH));
        af_d     = ((DEPTH - 32'(occ)) < AF_MARGIN);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            wcnt_q      <= '0;
            ovf_q       <= 1'b0;
            tmr_q       <= '0;
            pend_q      <= 1'b0;
            pend_good_q <= 1'b0;
            frm_cnt_q   <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            dvalid_q    <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_q      <= hold_d;
            wcnt_q      <= wcnt_d;
            ovf_q       <= ovf_d;
            tmr_q       <= tmr_d;
            pend_q      <= pend_d;
            pend_good_q <= pend_good_d;
            frm_cnt_q   <= frm_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            dvalid_q    <= dvalid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            af_q        <= af_d;
        end
    end

    assign bus.DOUT         = ram_rdata.data;
    assign bus.DOUT_LAST    = ram_rdata.last;
    assign bus.DOUT_VALID   = dvalid_q;
    assign bus.EMPTY        = empty_q;
    assign bus.FF_FULL      = full_q;
    assign bus.FF_AF        = af_q;
    assign bus.FRM_CNT      = frm_cnt_q;
    assign bus.GOOD_FRM_CNT = good_cnt_q;
    assign bus.BAD_FRM_CNT  = bad_cnt_q;

endmodule
